// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage byte/half/word load-store unit with read-modify-write sub-word stores
module mem_access_unit #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              misalign,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);
   typedef enum logic {IDLE, RMW_WR} state_t;
   state_t            state, state_next;
   logic [ADDR_W-1:0] rmw_addr;
   logic [31:0]       rmw_data, merged, shifted, load_val;
   logic [4:0]        sh_amt;
   logic              bad, load_ok, capture;
   logic              unused_addr;
   // Upper address bits are dropped so accesses wrap inside the memory.
   assign unused_addr = ^req_addr[31:ADDR_W+2];
   assign sh_amt = {req_addr[1:0], 3'b000};
   assign bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign shifted = mem_dout >> sh_amt;
   assign load_ok = state == IDLE && req_valid && !req_write && !bad;
   // Lane extraction with sign/zero extension; word loads pass through untouched.
   always_comb begin
      load_val = req_size == 2'b00 ? {{24{req_signed & shifted[7]}}, shifted[7:0]} :
                 req_size == 2'b01 ? {{16{req_signed & shifted[15]}}, shifted[15:0]} : mem_dout;
   end
   // Current memory word with the addressed lane(s) replaced by the store data.
   always_comb begin
      merged = req_size == 2'b00 ?
               (mem_dout & ~(32'h0000_00FF << sh_amt)) | ({24'd0, req_wdata[7:0]} << sh_amt) :
               (mem_dout & ~(32'h0000_FFFF << sh_amt)) | ({16'd0, req_wdata[15:0]} << sh_amt);
   end
   // Next state and memory/pipeline controls; stall and write drop as soon as reset asserts.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      mem_wen    = 1'b0;
      mem_addr   = req_addr[ADDR_W+1:2];
      mem_din    = req_wdata;
      capture    = 1'b0;
      if (state == RMW_WR) begin
         mem_addr   = rmw_addr;
         mem_din    = rmw_data;
         mem_wen    = !reset;
         state_next = IDLE;
      end else if (req_valid && req_write && !bad) begin
         if (req_size == 2'b10) begin
            mem_wen = !reset;
         end else begin
            stall      = !reset;
            capture    = 1'b1;
            state_next = RMW_WR;
         end
      end
   end
   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end
   // Latch address and merged word during the read phase of a sub-word store.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rmw_addr <= '0;
         rmw_data <= '0;
      end else if (capture) begin
         rmw_addr <= req_addr[ADDR_W+1:2];
         rmw_data <= merged;
      end
   end
   // Registered load result and misalignment pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata       <= '0;
         rdata_valid <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         rdata_valid <= load_ok;
         misalign    <= state == IDLE && req_valid && bad;
         if (load_ok) rdata <= load_val;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven check of loads, stores, read-modify-write and misalignment
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        stall, rdata_valid, misalign, mem_wen;
   logic [31:0] rdata, mem_din, mem_dout;
   logic [8:0]  mem_addr;
   logic [31:0] mem [0:511];
   int          checks = 0, failures = 0;

   typedef struct {
      logic        v, w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr, wdata;
      logic        e_stall, e_wen;
      logic [31:0] e_din;
      logic [8:0]  e_addr;
      logic        e_rv;
      logic [31:0] e_rdata;
      logic        e_mis;
   } vec_t;
   vec_t q[$];

   mem_access_unit #(.ADDR_W(9)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .misalign(misalign), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_din;

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step %0d got=%h exp=%h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = v; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = '0;
      //        v  w  sz     sg  addr          wdata         stall wen din           addr  rv rdata         mis
      q.push_back('{1, 1, 2'b10, 0, 32'h0000_000C, 32'h8899_AABB, 0, 1, 32'h8899_AABB, 9'd3, 0, 32'h0000_0000, 0});
      q.push_back('{1, 0, 2'b00, 1, 32'h0000_000D, 32'h0,         0, 0, 32'h0,         9'd3, 1, 32'hFFFF_FFAA, 0});
      q.push_back('{1, 0, 2'b00, 0, 32'h0000_000D, 32'h0,         0, 0, 32'h0,         9'd3, 1, 32'h0000_00AA, 0});
      q.push_back('{1, 1, 2'b01, 0, 32'h0000_000E, 32'h0000_1234, 1, 0, 32'h0,         9'd3, 0, 32'h0000_00AA, 0});
      q.push_back('{1, 1, 2'b01, 0, 32'h0000_000E, 32'h0000_1234, 0, 1, 32'h1234_AABB, 9'd3, 0, 32'h0000_00AA, 0});
      q.push_back('{1, 0, 2'b10, 0, 32'h0000_000C, 32'h0,         0, 0, 32'h0,         9'd3, 1, 32'h1234_AABB, 0});
      q.push_back('{1, 1, 2'b00, 0, 32'h0000_0010, 32'h0000_005A, 1, 0, 32'h0,         9'd4, 0, 32'h1234_AABB, 0});
      q.push_back('{1, 1, 2'b00, 0, 32'h0000_0010, 32'h0000_005A, 0, 1, 32'h0000_005A, 9'd4, 0, 32'h1234_AABB, 0});
      q.push_back('{1, 1, 2'b00, 0, 32'h0000_0011, 32'h0000_00A5, 1, 0, 32'h0,         9'd4, 0, 32'h1234_AABB, 0});
      q.push_back('{1, 1, 2'b00, 0, 32'h0000_0011, 32'h0000_00A5, 0, 1, 32'h0000_A55A, 9'd4, 0, 32'h1234_AABB, 0});
      q.push_back('{1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         0, 0, 32'h0,         9'd4, 1, 32'h0000_A55A, 0});
      q.push_back('{1, 0, 2'b10, 0, 32'h0000_0002, 32'h0,         0, 0, 32'h0,         9'd0, 0, 32'h0000_A55A, 1});
      q.push_back('{1, 1, 2'b01, 0, 32'h0000_0001, 32'h0000_FFFF, 0, 0, 32'h0,         9'd0, 0, 32'h0000_A55A, 1});
      q.push_back('{1, 0, 2'b11, 0, 32'h0000_0000, 32'h0,         0, 0, 32'h0,         9'd0, 0, 32'h0000_A55A, 1});
      q.push_back('{0, 0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 0, 32'h0,         9'd0, 0, 32'h0000_A55A, 0});
      q.push_back('{1, 1, 2'b10, 0, 32'h0000_0000, 32'h8001_0000, 0, 1, 32'h8001_0000, 9'd0, 0, 32'h0000_A55A, 0});
      q.push_back('{1, 0, 2'b01, 1, 32'h0000_0002, 32'h0,         0, 0, 32'h0,         9'd0, 1, 32'hFFFF_8001, 0});
      q.push_back('{1, 0, 2'b01, 0, 32'h0000_0002, 32'h0,         0, 0, 32'h0,         9'd0, 1, 32'h0000_8001, 0});
      q.push_back('{1, 1, 2'b10, 0, 32'h0000_0020, 32'h1122_3344, 0, 1, 32'h1122_3344, 9'd8, 0, 32'h0000_8001, 0});
      q.push_back('{1, 0, 2'b10, 0, 32'h8000_0810, 32'h0,         0, 0, 32'h0,         9'd4, 1, 32'h0000_A55A, 0});

      repeat (2) @(negedge clk);
      #1;
      chk("reset_rdata", 0, rdata, 32'h0);
      chk("reset_rv", 0, {31'd0, rdata_valid}, 32'h0);
      chk("reset_mis", 0, {31'd0, misalign}, 32'h0);
      chk("reset_wen", 0, {31'd0, mem_wen}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (q[i]) begin
         drive(q[i].v, q[i].w, q[i].sz, q[i].sg, q[i].addr, q[i].wdata);
         #1;
         chk("stall", i, {31'd0, stall}, {31'd0, q[i].e_stall});
         chk("mem_wen", i, {31'd0, mem_wen}, {31'd0, q[i].e_wen});
         chk("mem_addr", i, {23'd0, mem_addr}, {23'd0, q[i].e_addr});
         if (q[i].e_wen) chk("mem_din", i, mem_din, q[i].e_din);
         @(posedge clk);
         #1;
         chk("rdata_valid", i, {31'd0, rdata_valid}, {31'd0, q[i].e_rv});
         chk("rdata", i, rdata, q[i].e_rdata);
         chk("misalign", i, {31'd0, misalign}, {31'd0, q[i].e_mis});
         @(negedge clk);
      end
      chk("word4_mem", 100, mem[4], 32'h0000_A55A);

      // Reset in the write phase of sb 0xFF @0x20 must abort the write.
      drive(1, 1, 2'b00, 0, 32'h0000_0020, 32'h0000_00FF);
      #1;
      chk("abort_stall", 101, {31'd0, stall}, 32'h1);
      @(negedge clk);
      #1;
      chk("abort_rmw_wen", 102, {31'd0, mem_wen}, 32'h1);
      chk("abort_rmw_din", 102, mem_din, 32'h1122_33FF);
      reset = 1'b1;
      #1;
      chk("abort_wen_drop", 103, {31'd0, mem_wen}, 32'h0);
      chk("abort_stall_drop", 103, {31'd0, stall}, 32'h0);
      drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_mem", 104, mem[8], 32'h1122_3344);
      drive(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);
      #1;
      chk("post_reset_idle_addr", 105, {23'd0, mem_addr}, 32'd8);
      chk("post_reset_stall", 105, {31'd0, stall}, 32'h0);
      @(posedge clk);
      #1;
      chk("post_reset_rv", 106, {31'd0, rdata_valid}, 32'h1);
      chk("post_reset_lw", 106, rdata, 32'h1122_3344);
      @(negedge clk);
      drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
